// File: rtl/ins_fetcher_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package ins_fetcher_pkg;

  localparam int unsigned INS_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [6:0]  OPC_JAL    = 7'h6F;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  // One buffered instruction as seen by issue
  typedef struct packed {
    logic [INS_WIDTH-1:0]  code;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_jump;
  } iq_entry_t;

  // J-type immediate from instruction bits [31:12], sign-extended to 32 bits
  function automatic logic [ADDR_WIDTH-1:0] jal_imm(input logic [31:12] d);
    return {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ins_fetcher_queue.sv
// Synchronous instruction FIFO with push/pop/clear; clear wins over everything.
module ins_fetcher_queue
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  iq_entry_t               din,
  output iq_entry_t               head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop on empty is ignored; push on full only lands when a pop frees a slot
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: PC, icache req/ack FSM, JAL predecode and instruction queue.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned           QUEUE_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  ic_req_o,
  output logic [ADDR_WIDTH-1:0] ic_addr_o,
  input  logic                  ic_ack_i,
  input  logic [INS_WIDTH-1:0]  ic_data_i,
  output logic                  iq_valid_o,
  output logic [INS_WIDTH-1:0]  iq_code_o,
  output logic [ADDR_WIDTH-1:0] iq_pc_o,
  output logic                  iq_pred_jump_o,
  input  logic                  issue_ready_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  if_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  push, pop, clr, is_jal;
  iq_entry_t             entry, head;
  logic [CNT_W-1:0]      count;

  // Next state, next PC, request control and queue strobes
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = ic_req_o;
    addr_d  = ic_addr_o;
    push    = 1'b0;
    clr     = 1'b0;
    pop     = iq_valid_o && issue_ready_i;
    is_jal  = (ic_data_i[6:0] == OPC_JAL);
    entry   = '{code: ic_data_i, pc: pc_q, pred_jump: is_jal};
    unique case (state_q)
      IF_IDLE: begin
        if (!flush_i && (count < CNT_W'(QUEUE_DEPTH))) begin
          state_d = IF_WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      IF_WAIT: begin
        if (ic_ack_i) begin
          state_d = IF_IDLE;
          req_d   = 1'b0;
          push    = 1'b1;
          pc_d    = is_jal ? pc_q + jal_imm(ic_data_i[31:12]) : pc_q + ADDR_WIDTH'(4);
        end else if (flush_i) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        // The stale request completes here; its data is thrown away
        if (ic_ack_i) begin
          state_d = IF_IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (flush_i) begin
      clr  = 1'b1;
      push = 1'b0;
      pc_d = flush_pc_i;
    end
  end

  // State, PC and icache request registers; rdy_in low freezes them
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      ic_req_o  <= 1'b0;
      ic_addr_o <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ic_req_o  <= req_d;
      ic_addr_o <= addr_d;
    end
  end

  ins_fetcher_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (clr  && rdy_in),
    .push   (push && rdy_in),
    .pop    (pop  && rdy_in),
    .din    (entry),
    .head   (head),
    .count  (count)
  );

  assign iq_valid_o     = (count != '0);
  assign iq_code_o      = head.code;
  assign iq_pc_o        = head.pc;
  assign iq_pred_jump_o = head.pred_jump;

endmodule
